// File: rtl/addsub_pipe.sv
// Pipelined N-bit add/subtract with carry/borrow chaining, status flags
// and a valid/ready handshake; one SEG-bit carry segment per stage.
module addsub_pipe #(
    parameter int N   = 16,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [N-1:0] rs1_reg,
    input  logic [N-1:0] rs2_reg,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res_rd,
    output logic         bo,
    output logic         ovf,
    output logic         zero,
    output logic         neg
);

    localparam int STAGES = N / SEG;
    localparam int L      = STAGES - 1;

    logic [N-1:0]      a_q [STAGES];
    logic [N-1:0]      b_q [STAGES];
    logic [N-1:0]      r_q [STAGES];
    logic [STAGES-1:0] v_q, op_q, c_q, z_q;

    logic [N-1:0]      a_d [STAGES];
    logic [N-1:0]      b_d [STAGES];
    logic [N-1:0]      r_d [STAGES];
    logic [STAGES-1:0] v_d, op_d, c_d, z_d;

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // The operand b is stored already inverted for subtract, so every
    // stage is a plain adder and the overflow rule is the add rule.
    always_comb begin
        logic [N-1:0] a_p, b_p, r_p;
        logic         v_p, op_p, c_p, z_p;
        logic [SEG:0] sum;
        a_p  = rs1_reg;
        b_p  = op ? ~rs2_reg : rs2_reg;
        r_p  = '0;
        v_p  = in_valid;
        op_p = op;
        c_p  = bin ^ op;
        z_p  = 1'b1;
        sum  = '0;
        for (int k = 0; k < STAGES; k++) begin
            sum = {1'b0, a_p[k*SEG +: SEG]}
                + {1'b0, b_p[k*SEG +: SEG]}
                + {{SEG{1'b0}}, c_p};
            a_d[k]                = a_p;
            b_d[k]                = b_p;
            r_d[k]                = r_p;
            r_d[k][k*SEG +: SEG]  = sum[SEG-1:0];
            v_d[k]                = v_p;
            op_d[k]               = op_p;
            c_d[k]                = sum[SEG];
            z_d[k]                = z_p && (sum[SEG-1:0] == '0);
            a_p  = a_q[k];
            b_p  = b_q[k];
            r_p  = r_q[k];
            v_p  = v_q[k];
            op_p = op_q[k];
            c_p  = c_q[k];
            z_p  = z_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q  <= '0;
            op_q <= '0;
            c_q  <= '0;
            z_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else if (advance) begin
            v_q  <= v_d;
            op_q <= op_d;
            c_q  <= c_d;
            z_q  <= z_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                r_q[k] <= r_d[k];
            end
        end
    end

    // Flags are resolved from the last stage into the output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res_rd    <= '0;
            bo        <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else if (advance) begin
            out_valid <= v_q[L];
            if (v_q[L]) begin
                res_rd <= r_q[L];
                bo     <= c_q[L] ^ op_q[L];
                ovf    <= (a_q[L][N-1] == b_q[L][N-1])
                       && (r_q[L][N-1] != a_q[L][N-1]);
                zero   <= z_q[L];
                neg    <= r_q[L][N-1];
            end
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed vectors, stall/reset
// sequences and a randomised sweep over three width/segment configs.
module tb_addsub_pipe;

    typedef struct packed {
        logic [31:0] res;
        logic        bo;
        logic        ovf;
        logic        zero;
        logic        neg;
    } rec_t;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] res;
        logic        bo;
        logic        ovf;
        logic        zero;
        logic        neg;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] rs1, rs2;
    logic op, bin;

    logic iv_a, or_a, ir_a, ov_a, bo_a, ovf_a, zero_a, neg_a;
    logic [15:0] res_a;
    logic iv_b, or_b, ir_b, ov_b, bo_b, ovf_b, zero_b, neg_b;
    logic [31:0] res_b;
    logic iv_c, or_c, ir_c, ov_c, bo_c, ovf_c, zero_c, neg_c;
    logic [7:0] res_c;

    int n_chk = 0;
    int n_fail = 0;
    int dlv_a = 0;
    rec_t qa[$], qb[$], qc[$];

    always #5 clk = ~clk;

    addsub_pipe #(.N(16), .SEG(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a),
        .op(op), .rs1_reg(rs1[15:0]), .rs2_reg(rs2[15:0]), .bin(bin),
        .out_valid(ov_a), .out_ready(or_a), .res_rd(res_a),
        .bo(bo_a), .ovf(ovf_a), .zero(zero_a), .neg(neg_a)
    );

    addsub_pipe #(.N(32), .SEG(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b),
        .op(op), .rs1_reg(rs1), .rs2_reg(rs2), .bin(bin),
        .out_valid(ov_b), .out_ready(or_b), .res_rd(res_b),
        .bo(bo_b), .ovf(ovf_b), .zero(zero_b), .neg(neg_b)
    );

    addsub_pipe #(.N(8), .SEG(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c),
        .op(op), .rs1_reg(rs1[7:0]), .rs2_reg(rs2[7:0]), .bin(bin),
        .out_valid(ov_c), .out_ready(or_c), .res_rd(res_c),
        .bo(bo_c), .ovf(ovf_c), .zero(zero_c), .neg(neg_c)
    );

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic rec_t model(int w, logic o, logic [31:0] a,
                                   logic [31:0] b, logic ci);
        rec_t r;
        longint m, half, ua, ub, sa, sb, full, sr;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'({32'b0, a}) & m;
        ub   = longint'({32'b0, b}) & m;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        if (!o) begin
            full = ua + ub + longint'(ci);
            sr   = sa + sb + longint'(ci);
            r.bo = ((full >> w) & 1) != 0;
        end else begin
            full = ua - ub - longint'(ci);
            sr   = sa - sb - longint'(ci);
            r.bo = ua < ub + longint'(ci);
        end
        r.res  = 32'(full & m);
        r.ovf  = (sr >= half) || (sr < -half);
        r.zero = (full & m) == 0;
        r.neg  = ((full >> (w - 1)) & 1) != 0;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) qa.delete();
        else begin
            if (ov_a && or_a) begin
                check("a_not_extra", 64'(qa.size() != 0), 64'd1);
                if (qa.size() != 0) begin
                    check("a_out", {16'h0, res_a, bo_a, ovf_a, zero_a, neg_a},
                          qa.pop_front());
                    dlv_a++;
                end
            end
            if (iv_a && ir_a) qa.push_back(model(16, op, rs1, rs2, bin));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) qb.delete();
        else begin
            if (ov_b && or_b) begin
                check("b_not_extra", 64'(qb.size() != 0), 64'd1);
                if (qb.size() != 0)
                    check("b_out", {res_b, bo_b, ovf_b, zero_b, neg_b},
                          qb.pop_front());
            end
            if (iv_b && ir_b) qb.push_back(model(32, op, rs1, rs2, bin));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) qc.delete();
        else begin
            if (ov_c && or_c) begin
                check("c_not_extra", 64'(qc.size() != 0), 64'd1);
                if (qc.size() != 0)
                    check("c_out", {24'h0, res_c, bo_c, ovf_c, zero_c, neg_c},
                          qc.pop_front());
            end
            if (iv_c && ir_c) qc.push_back(model(8, op, rs1, rs2, bin));
        end
    end

    task automatic wait_lat(string nm, int want);
        int lat;
        lat = 0;
        while (!ov_a && lat < 12) begin
            step();
            lat++;
        end
        check(nm, 64'(lat), 64'(want));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        logic [15:0] held;
        int sent, d0;

        vt[0] = '{1'b1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 0, 0, 0, 0};
        vt[1] = '{1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1, 0, 0, 1};
        vt[2] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 0, 1, 0, 0};
        vt[3] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 1, 0};
        vt[4] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 0, 1, 0, 1};
        vt[5] = '{1'b1, 16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1, 0, 0, 1};
        vt[6] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1, 1, 1, 0};
        vt[7] = '{1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 0, 0, 1, 0};

        rst_n = 1'b0;
        rs1 = '0; rs2 = '0; op = 1'b0; bin = 1'b0;
        iv_a = 1'b0; or_a = 1'b1;
        iv_b = 1'b0; or_b = 1'b1;
        iv_c = 1'b0; or_c = 1'b1;
        repeat (3) step();
        check("rst_out", {ov_a, res_a, bo_a, ovf_a, zero_a, neg_a}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(ir_a), 64'd1);

        for (int i = 0; i < 8; i++) begin
            step();
            op = vt[i].op; bin = vt[i].ci;
            rs1 = {16'h0, vt[i].a}; rs2 = {16'h0, vt[i].b};
            iv_a = 1'b1;
            step();
            iv_a = 1'b0;
            wait_lat($sformatf("vec%0d_lat", i), 4);
            check($sformatf("vec%0d", i),
                  {res_a, bo_a, ovf_a, zero_a, neg_a},
                  {vt[i].res, vt[i].bo, vt[i].ovf, vt[i].zero, vt[i].neg});
        end
        repeat (6) step();

        // Eight back-to-back beats with a three-cycle consumer stall.
        d0 = dlv_a;
        sent = 0;
        held = '0;
        for (int c = 0; c < 30; c++) begin
            step();
            or_a = !(c >= 6 && c <= 8);
            iv_a = sent < 8;
            rs1 = $urandom; rs2 = $urandom;
            op = 1'($urandom); bin = 1'($urandom);
            #1;
            if (iv_a && ir_a) sent++;
            if (c >= 6 && c <= 8) begin
                check("stall_in_ready", 64'(ir_a), 64'd0);
                check("stall_out_valid", 64'(ov_a), 64'd1);
                if (c == 6) held = res_a;
                else check("stall_hold", 64'(res_a), 64'(held));
            end
        end
        iv_a = 1'b0; or_a = 1'b1;
        repeat (8) step();
        check("stream_count", 64'(dlv_a - d0), 64'd8);
        check("stream_drained", 64'(qa.size()), 64'd0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            step();
            iv_a = 1'b1;
            rs1 = $urandom; rs2 = $urandom;
            op = 1'($urandom); bin = 1'($urandom);
        end
        step();
        iv_a = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_out", {ov_a, res_a, bo_a, ovf_a, zero_a, neg_a}, 64'd0);
        check("midrst_in_ready", 64'(ir_a), 64'd1);
        op = 1'b0; bin = 1'b0;
        rs1 = 32'h0000_0100; rs2 = 32'h0000_0023;
        iv_a = 1'b1;
        step();
        iv_a = 1'b0;
        wait_lat("midrst_lat", 4);
        check("midrst_res", 64'(res_a), 64'h0123);
        repeat (3) step();
        check("midrst_no_ghost", 64'(qa.size()), 64'd0);

        // Randomised sweep across all three configurations.
        for (int c = 0; c < 400; c++) begin
            step();
            rs1 = $urandom; rs2 = $urandom;
            case ($urandom_range(0, 7))
                0: rs2 = rs1;
                1: rs1 = 32'h8000_8080;
                2: rs2 = 32'hFFFF_FFFF;
                3: rs1 = 32'h7FFF_7F7F;
                default: ;
            endcase
            op = 1'($urandom); bin = 1'($urandom);
            iv_a = $urandom_range(0, 3) != 0;
            iv_b = $urandom_range(0, 3) != 0;
            iv_c = $urandom_range(0, 3) != 0;
            or_a = $urandom_range(0, 3) != 0;
            or_b = $urandom_range(0, 3) != 0;
            or_c = $urandom_range(0, 3) != 0;
        end
        step();
        iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
        or_a = 1'b1; or_b = 1'b1; or_c = 1'b1;
        repeat (10) step();
        check("sweep_a_drained", 64'(qa.size()), 64'd0);
        check("sweep_b_drained", 64'(qb.size()), 64'd0);
        check("sweep_c_drained", 64'(qc.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined N-bit add/subtract unit with carry/borrow chaining, status flags and a valid/ready handshake. It is the sequential successor of the team's combinational ripple-borrow subtractor. The carry chain is split into SEG-bit segments, one per pipeline stage, so wide operands close timing at full clock rate. It sits between the register-read stage and the ALU result mux and issues one operation per cycle.

## Interface
- N, 16: operand/result width; must be a multiple of SEG.
- SEG, 4: bits resolved per pipeline stage; STAGES = N/SEG (SEG = N gives a single stage).
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- op  in  1  0 = add (rs1_reg + rs2_reg + bin); 1 = subtract (rs1_reg - rs2_reg - bin).
- rs1_reg  in  N  first operand.
- rs2_reg  in  N  second operand.
- bin  in  1  carry-in (add) / borrow-in (subtract).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result this cycle.
- res_rd  out  N  result.
- bo  out  1  carry-out (add) / borrow-out (subtract).
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  res_rd == 0.
- neg  out  1  res_rd[N-1].

## Operation
- Beat accepted on a rising edge with in_valid && in_ready. Result delivered on a rising edge with out_valid && out_ready.
- Subtract is implemented as rs1 + ~rs2 + ~bin. Internal carry-in = bin ^ op. Reported bo = final carry ^ op.
- Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] using the registered carry from stage k-1.
- Unprocessed operand segments are skewed forward through pipeline registers. Completed result segments are carried alongside.
- Each stage holds: valid bit, op, partial result, carry, and a running zero accumulator (AND of "segment == 0").
- Signed overflow is computed in the last stage from the operand MSBs and result MSB:
  - add: ovf = (a_msb == b_msb) && (r_msb != a_msb)
  - sub: ovf = (a_msb != b_msb) && (r_msb != a_msb)
- Flow control is a global stall:
  - advance = !out_valid || out_ready; in_ready = advance.
  - When advance = 0, every stage register, including outputs, holds.
  - Bubbles (in_valid = 0 while advancing) propagate as invalid stages.
- No reordering or dropping. Results emerge in acceptance order.
- Arithmetic is unsigned modulo 2^N for res_rd; bo is the (N+1)th bit per the rules above.
- No internal state machine beyond the per-stage valid bits.

## Timing
- Reset (rst_n = 0 at a rising edge): all stage valid bits clear; out_valid = 0; res_rd = 0; bo, ovf, zero, neg = 0. in_ready = 1 from the first cycle after reset.
- Reset mid-stream discards all in-flight beats. No partial result is emitted after reset.
- Latency: a beat accepted at edge T gives out_valid = 1 after edge T + STAGES, assuming no stall. Each stall cycle adds one cycle.
- Throughput: 1 beat/cycle while out_ready = 1.
- All outputs are registered. res_rd and the flags stay stable while out_valid && !out_ready.
- in_ready depends combinationally on out_ready (single-level path).
- Simultaneous accept and deliver in the same cycle is legal and required for full throughput.
- With SEG = N, behaviour is identical with STAGES = 1.

## Test plan
- N=16, SEG=4, op=1, 0x0005 - 0x0003, bin=0 -> after 4 cycles: res_rd=0x0002, bo=0, ovf=0, zero=0, neg=0.
- op=1, 0x0000 - 0x0001, bin=0 -> res_rd=0xFFFF, bo=1, neg=1, ovf=0. Also op=1, 0x8000 - 0x0001 -> 0x7FFF, ovf=1, bo=0.
- op=0, 0xFFFF + 0x0001, bin=0 -> 0x0000, bo=1, zero=1. Also op=0, 0x7FFF + 0x0000, bin=1 -> 0x8000, ovf=1, neg=1.
- Back-to-back stream of 8 mixed add/sub beats; hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held, all 8 results correct and in order, no duplicates.
- Assert rst_n=0 for 1 cycle with 3 beats in flight -> next cycle out_valid=0, all outputs 0, in_ready=1. The next accepted beat emerges after exactly STAGES cycles.
- Randomised sweep at (N=16,SEG=4), (N=32,SEG=8) and (N=8,SEG=8): compare against a reference model of a-b-bin / a+b+bin; all flags match.
